// File: rtl/led_sweep_pkg.sv
// rtl/led_sweep_pkg.sv - shared mode and state encodings for the LED sweep sequencer
package led_sweep_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROTL   = 2'b01,
        MODE_ROTR   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DWELL = 2'b10
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - step-period counter producing one tick every period+1 enabled cycles
module tick_prescaler #(
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == period);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_sweep_ctrl.sv
// rtl/led_sweep_ctrl.sv - one-hot LED sweep sequencer with bounce/dwell and rotate modes
module led_sweep_ctrl
    import led_sweep_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned DWELL_W  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [WIDTH-1:0]    count,
    output logic                busy,
    output logic                step,
    output logic                wrap
);

    localparam int unsigned POS_W = $clog2(WIDTH);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dir_down_q, dir_down_d;
    logic                step_q, step_d;
    logic                wrap_q, wrap_d;
    logic                tick;

    assign busy  = (state_q != ST_IDLE);
    assign count = WIDTH'(1) << pos_q;
    assign step  = step_q;
    assign wrap  = wrap_q;

    tick_prescaler #(.PERIOD_W(PERIOD_W)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clr    (start || stop),
        .en     (busy),
        .period (period_q),
        .tick   (tick)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        period_d    = period_q;
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_cnt_q;
        pos_d       = pos_q;
        dir_down_d  = dir_down_q;
        step_d      = 1'b0;
        wrap_d      = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            // Dwell decision uses the incoming config, since it is latched on this same edge
            mode_d     = mode_e'(mode);
            period_d   = period;
            dwell_d    = dwell;
            pos_d      = '0;
            dir_down_d = 1'b0;
            if ((mode_e'(mode) == MODE_BOUNCE) && (dwell != '0)) begin
                state_d     = ST_DWELL;
                dwell_cnt_d = dwell;
            end else begin
                state_d = ST_RUN;
            end
        end else if (tick) begin
            case (state_q)
                ST_RUN: begin
                    case (mode_q)
                        MODE_BOUNCE: begin
                            step_d = 1'b1;
                            if (!dir_down_q) begin
                                pos_d = pos_q + POS_W'(1);
                                if (pos_q == POS_MAX - POS_W'(1)) dir_down_d = 1'b1;
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                                if (pos_q == POS_W'(1)) begin
                                    dir_down_d = 1'b0;
                                    wrap_d     = 1'b1;
                                    if (dwell_q != '0) begin
                                        state_d     = ST_DWELL;
                                        dwell_cnt_d = dwell_q;
                                    end
                                end
                            end
                        end
                        MODE_ROTL: begin
                            step_d = 1'b1;
                            if (pos_q == POS_MAX) begin
                                pos_d  = '0;
                                wrap_d = 1'b1;
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                            end
                        end
                        MODE_ROTR: begin
                            step_d = 1'b1;
                            if (pos_q == '0) begin
                                pos_d  = POS_MAX;
                                wrap_d = 1'b1;
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
                ST_DWELL: begin
                    if (dwell_cnt_q == DWELL_W'(1)) begin
                        state_d = ST_RUN;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_BOUNCE;
            period_q    <= '0;
            dwell_q     <= '0;
            dwell_cnt_q <= '0;
            pos_q       <= '0;
            dir_down_q  <= 1'b0;
            step_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            period_q    <= period_d;
            dwell_q     <= dwell_d;
            dwell_cnt_q <= dwell_cnt_d;
            pos_q       <= pos_d;
            dir_down_q  <= dir_down_d;
            step_q      <= step_d;
            wrap_q      <= wrap_d;
        end
    end

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// tb/tb_led_sweep_ctrl.sv - table-driven scoreboard bench for led_sweep_ctrl
module tb_led_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] period = 16'd0;
    logic [2:0]  dwell = 3'd0;
    logic [7:0]  count;
    logic        busy, step, wrap;

    always #5 clk = ~clk;

    led_sweep_ctrl #(.WIDTH(8), .PERIOD_W(16), .DWELL_W(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stop   (stop),
        .mode   (mode),
        .period (period),
        .dwell  (dwell),
        .count  (count),
        .busy   (busy),
        .step   (step),
        .wrap   (wrap)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        st;
        logic        sp;
        logic [1:0]  md;
        logic [15:0] per;
        logic [2:0]  dw;
        logic [7:0]  e_count;
        logic        e_busy;
        logic        e_step;
        logic        e_wrap;
    } vec_t;

    typedef struct packed {
        logic [7:0] c;
        logic       b;
        logic       s;
        logic       w;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   passed = 0;
    int   total = 0;

    logic [7:0] bseq [18] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};

    function automatic void add(input string nm, input logic r, input logic s0, input logic s1,
                                input logic [1:0] m, input logic [15:0] p, input logic [2:0] d,
                                input logic [7:0] c, input logic b, input logic s, input logic w);
        vec_t v;
        v.name = nm; v.rst = r; v.st = s0; v.sp = s1; v.md = m; v.per = p; v.dw = d;
        v.e_count = c; v.e_busy = b; v.e_step = s; v.e_wrap = w;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input logic [10:0] got, input logic [10:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got count=%h busy=%b step=%b wrap=%b, want count=%h busy=%b step=%b wrap=%b",
                      nm, got[10:3], got[2], got[1], got[0], exp[10:3], exp[2], exp[1], exp[0]);
    endtask

    initial begin
        int n;
        exp_t e;

        add("reset", 1, 0, 0, 2'b00, 16'd0, 3'd0, 8'h01, 0, 0, 0);
        add("reset", 1, 0, 0, 2'b00, 16'd0, 3'd0, 8'h01, 0, 0, 0);
        for (int i = 0; i < 10; i++) add("idle", 0, 0, 0, 2'b01, 16'd2, 3'd5, 8'h01, 0, 0, 0);

        // Bounce with dwell 4: 18-cycle repeating pattern, config inputs garbled after start
        add("bounce_start", 0, 1, 0, 2'b00, 16'd0, 3'd4, 8'h01, 1, 0, 0);
        for (int k = 1; k <= 40; k++)
            add("bounce", 0, 0, 0, 2'b11, 16'd7, 3'd1, bseq[k % 18], 1,
                (k % 18 >= 5) || (k % 18 == 0), (k % 18 == 0));

        // Stop at 0x10, start+stop together, then rotate-left with period 3
        add("b0_start", 0, 1, 0, 2'b00, 16'd0, 3'd0, 8'h01, 1, 0, 0);
        for (int k = 1; k <= 4; k++)
            add("b0_run", 0, 0, 0, 2'b00, 16'd0, 3'd0, 8'(1 << k), 1, 1, 0);
        add("stop", 0, 0, 1, 2'b00, 16'd0, 3'd0, 8'h10, 0, 0, 0);
        add("stopped", 0, 0, 0, 2'b00, 16'd0, 3'd0, 8'h10, 0, 0, 0);
        add("stopped", 0, 0, 0, 2'b00, 16'd0, 3'd0, 8'h10, 0, 0, 0);
        add("start_stop", 0, 1, 1, 2'b00, 16'd0, 3'd0, 8'h10, 0, 0, 0);
        add("rotl_start", 0, 1, 0, 2'b01, 16'd3, 3'd0, 8'h01, 1, 0, 0);
        for (int k = 1; k <= 36; k++)
            add("rotl", 0, 0, 0, 2'b10, 16'd0, 3'd2, 8'(1 << ((k / 4) % 8)), 1,
                (k % 4 == 0), (k % 32 == 0));

        add("rotr_start", 0, 1, 0, 2'b10, 16'd0, 3'd0, 8'h01, 1, 0, 0);
        for (int k = 1; k <= 17; k++)
            add("rotr", 0, 0, 0, 2'b00, 16'd9, 3'd3, 8'(1 << ((8 - k % 8) % 8)), 1, 1, (k % 8 == 1));

        add("hold_start", 0, 1, 0, 2'b11, 16'd0, 3'd0, 8'h01, 1, 0, 0);
        for (int k = 1; k <= 3; k++) add("hold", 0, 0, 0, 2'b01, 16'd0, 3'd0, 8'h01, 1, 0, 0);

        // Reset while in DWELL, then a fresh start behaves as from power-up
        add("dw_start", 0, 1, 0, 2'b00, 16'd1, 3'd3, 8'h01, 1, 0, 0);
        add("dwell", 0, 0, 0, 2'b00, 16'd1, 3'd3, 8'h01, 1, 0, 0);
        add("dwell", 0, 0, 0, 2'b00, 16'd1, 3'd3, 8'h01, 1, 0, 0);
        add("dw_reset", 1, 0, 0, 2'b00, 16'd1, 3'd3, 8'h01, 0, 0, 0);
        add("post_rst", 0, 0, 0, 2'b01, 16'd0, 3'd0, 8'h01, 0, 0, 0);
        add("post_rst", 0, 0, 0, 2'b01, 16'd0, 3'd0, 8'h01, 0, 0, 0);
        add("pr_start", 0, 1, 0, 2'b00, 16'd0, 3'd0, 8'h01, 1, 0, 0);
        add("pr_run", 0, 0, 0, 2'b00, 16'd0, 3'd0, 8'h02, 1, 1, 0);
        add("pr_run", 0, 0, 0, 2'b00, 16'd0, 3'd0, 8'h04, 1, 1, 0);
        add("pr_stop", 0, 0, 1, 2'b00, 16'd0, 3'd0, 8'h04, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; start = vecs[i].st; stop = vecs[i].sp;
            mode = vecs[i].md; period = vecs[i].per; dwell = vecs[i].dw;
            sb.push_back('{vecs[i].e_count, vecs[i].e_busy, vecs[i].e_step, vecs[i].e_wrap});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("%s[%0d]", vecs[i].name, i), {count, busy, step, wrap}, e);
        end

        // First tick latency: period 5 means the first step shows 6 cycles after the start edge
        @(negedge clk);
        reset = 0; stop = 0; start = 1; mode = 2'b00; period = 16'd5; dwell = 3'd0;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 0;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (step) break;
        end
        total++;
        if (n == 6) passed++;
        else $display("FAIL first_tick_latency: got %0d cycles, want 6", n);
        check("first_step_value", {count, busy, step, wrap}, {8'h02, 1'b1, 1'b1, 1'b0});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/led_sweep_ctrl.md
Name: led_sweep_ctrl

Overview:
Sequencer for a one-hot LED sweep display. It generates a programmable step tick, a position/direction state machine and a one-hot output. It supports bounce ("Knight Rider") sweeps with a configurable dwell at position 0, plus left/right rotation. It sits between the board control inputs (buttons/switches) and the LED bank, and generalises a fixed-pattern shift counter into a configurable, start/stop-controlled block.

Parameters:
WIDTH, 8, number of LEDs / output bits (≥2)
PERIOD_W, 16, width of step-period config
DWELL_W, 3, width of dwell config

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  pulse: latch config and (re)start sweep
stop  input  1  pulse: halt sweep, freeze output
mode  input  2  00 bounce, 01 rotate left (toward MSB), 10 rotate right, 11 hold
period  input  PERIOD_W  clock cycles per step minus 1
dwell  input  DWELL_W  extra ticks held at position 0 in bounce mode
count  output  WIDTH  one-hot LED pattern, bit pos set
busy  output  1  high while sweep is active (RUN or DWELL)
step  output  1  one-cycle pulse, coincident with each count change
wrap  output  1  one-cycle pulse when a full pattern cycle completes

Behaviour:
- Reset (highest priority, any state): state IDLE, pos=0 (count=0x01), dir=up, prescaler=0, dwell_cnt=0, busy=0, step=0, wrap=0, shadow config=0.
- States: IDLE, RUN, DWELL. busy=1 in RUN/DWELL.
- start (any state): on the next edge latch mode/period/dwell into shadow regs. Set pos=0, dir=up, prescaler=0. If mode_q=bounce and dwell_q>0, enter DWELL with dwell_cnt=dwell_q; otherwise enter RUN. step is not pulsed on start.
- stop: go to IDLE. pos and count hold their last value. Prescaler cleared. stop has priority over a simultaneous start.
- Config inputs are ignored except on start. Changing them mid-sweep has no effect.
- Tick: prescaler counts 0..period_q while busy. Tick is asserted when prescaler==period_q, then prescaler returns to 0. period_q=0 gives a tick every cycle. The first tick is period_q+1 cycles after the start edge.
- RUN on tick:
  - bounce, dir up: pos+1; on reaching WIDTH-1, dir=down.
  - bounce, dir down: pos-1; on reaching 0, dir=up, wrap pulse, and enter DWELL with dwell_cnt=dwell_q if dwell_q>0.
  - rotate left: pos=(pos+1) mod WIDTH; wrap pulse on the WIDTH-1→0 transition.
  - rotate right: pos=(pos-1) mod WIDTH; wrap pulse on the 0→WIDTH-1 transition.
  - hold: pos unchanged, no step/wrap.
- DWELL on tick: if dwell_cnt==1, go to RUN; else dwell_cnt-1. pos unchanged, no step. Position 0 is therefore visible for dwell_q+1 ticks per bounce cycle.
- Bounce cycle length is 2*(WIDTH-1)+dwell_q ticks. With WIDTH=8 and dwell=4 this is 18 ticks.
- step and wrap are registered. They are high exactly in the first cycle count shows the new value. They are never asserted in IDLE.
- count = 1<<pos, decoded from the pos register; always exactly one bit set, never X. pos width is clog2(WIDTH).

Decomposition:
- led_sweep_pkg: mode constants (MODE_BOUNCE, MODE_ROTL, MODE_ROTR, MODE_HOLD), state encoding (ST_IDLE, ST_RUN, ST_DWELL).
- Sub-module tick_prescaler (ports clk, reset, clr, en, period, tick): free-running period counter. The FSM, position/direction logic and one-hot decode stay in led_sweep_ctrl.

Test Plan:
- Reset then idle 10 cycles -> count=0x01, busy=0, step=0, wrap=0 throughout.
- start with mode=00, period=0, dwell=4, run 40 cycles -> after the initial dwell, a repeating 18-cycle sequence 01,01,01,01,01,02,04,08,10,20,40,80,40,20,10,08,04,02; wrap pulses every 18 cycles on the 02→01 step.
- mode=01, period=3, dwell=0 -> count shifts left every 4 cycles 01→02→…→80→01; step every 4th cycle; wrap on 80→01.
- mode=10, period=0 -> 01→80→40…; wrap on the 01→80 step.
- Running bounce at count=0x10: assert stop -> count frozen at 0x10, busy=0 next cycle. Assert start and stop together -> stays IDLE. Then start alone -> count=0x01, busy=1.
- Mid-sweep: change period/mode without start -> no effect. Assert reset mid-DWELL -> all outputs at reset values after the next edge; start afterwards behaves as from power-up.
